// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch aligner.
// Halfword type, bubble encoding and RVC detection.
package fetch_pkg;

    typedef logic [15:0] hw_t;

    localparam logic [31:0] INS_BUBBLE = 32'h0;

    // A halfword starts a compressed instruction unless its low bits are 2'b11.
    function automatic logic is_rvc(hw_t hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/halfword_fifo.sv
// Halfword FIFO: 0/1/2 halfword push (push0 first), 0/1/2 pop, two-entry head view.
// Ports: clk, Rst, clear, push_n_i, push0_i, push1_i, pop_n_i, head0_o, head1_o, count_o.
module halfword_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          Rst,
    input  logic          clear,
    input  logic [1:0]    push_n_i,
    input  hw_t           push0_i,
    input  hw_t           push1_i,
    input  logic [1:0]    pop_n_i,
    output hw_t           head0_o,
    output hw_t           head1_o,
    output logic [CW-1:0] count_o
);

    hw_t           mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wr_d    = wr_q + PW'(push_n_i);
        rd_d    = rd_q + PW'(pop_n_i);
        count_d = count_q + CW'(push_n_i) - CW'(pop_n_i);
        if (clear) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; count guards every read.
    always_ff @(posedge clk) begin
        if (push_n_i != 2'd0) begin
            mem_q[wr_q] <= push0_i;
        end
        if (push_n_i == 2'd2) begin
            mem_q[wr_q + PW'(1)] <= push1_i;
        end
    end

    assign head0_o = mem_q[rd_q];
    assign head1_o = mem_q[rd_q + PW'(1)];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_aligner.sv
// Fetch aligner: turns aligned imem words into RVC/32-bit instructions for Decode.
// Ports: clk, Rst, imem (fetch_addr, fw_*), control (stall, freeze, redirect*), IF/ID outputs.
module fetch_aligner
    import fetch_pkg::*;
#(
    parameter int               ADDR_W     = 32,
    parameter int               HW_DEPTH   = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              Rst,
    output logic [ADDR_W-1:0] fetch_addr,
    input  logic              fw_valid,
    output logic              fw_ready,
    input  logic [31:0]       fw_data,
    input  logic              stall,
    input  logic              freeze,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [31:0]       ins,
    output logic              comp_sig,
    output logic [ADDR_W-1:0] IF_ID_pres_addr,
    output logic              ins_valid
);

    localparam int CW = $clog2(HW_DEPTH) + 1;
    localparam logic [CW-1:0] ROOM2 = CW'(HW_DEPTH - 2);

    logic [ADDR_W-1:0] fa_q, fa_d;
    logic [ADDR_W-1:0] hpc_q, hpc_d;
    logic              drop_q, drop_d;
    logic [31:0]       ins_q, ins_d;
    logic              comp_q, comp_d;
    logic              val_q, val_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    hw_t           head0, head1;
    logic [CW-1:0] count;
    logic [1:0]    push_n, pop_n;
    hw_t           push0;
    logic          push, head_rvc, complete, pop, clear;

    halfword_fifo #(.DEPTH(HW_DEPTH)) u_fifo (
        .clk      (clk),
        .Rst      (Rst),
        .clear    (clear),
        .push_n_i (push_n),
        .push0_i  (push0),
        .push1_i  (fw_data[31:16]),
        .pop_n_i  (pop_n),
        .head0_o  (head0),
        .head1_o  (head1),
        .count_o  (count)
    );

    // No same-cycle pop credit: room is judged on the current count only.
    assign fw_ready = !Rst && !freeze && !redirect && (count <= ROOM2);
    assign push     = fw_valid && fw_ready;
    assign push_n   = !push ? 2'd0 : (drop_q ? 2'd1 : 2'd2);
    assign push0    = drop_q ? fw_data[31:16] : fw_data[15:0];

    assign head_rvc = is_rvc(head0);
    assign complete = head_rvc ? (count >= CW'(1)) : (count >= CW'(2));
    assign pop      = !Rst && !freeze && !redirect && !stall && complete;
    assign pop_n    = !pop ? 2'd0 : (head_rvc ? 2'd1 : 2'd2);
    assign clear    = !freeze && redirect;

    always_comb begin
        fa_d   = fa_q;
        hpc_d  = hpc_q;
        drop_d = drop_q;
        ins_d  = ins_q;
        comp_d = comp_q;
        val_d  = val_q;
        pc_d   = pc_q;
        if (freeze) begin
            // hold everything
        end else if (redirect) begin
            fa_d   = {redirect_addr[ADDR_W-1:2], 2'b00};
            hpc_d  = redirect_addr;
            drop_d = redirect_addr[1];
            ins_d  = INS_BUBBLE;
            comp_d = 1'b0;
            val_d  = 1'b0;
        end else begin
            if (push) begin
                fa_d   = fa_q + ADDR_W'(4);
                drop_d = 1'b0;
            end
            if (!stall) begin
                if (complete) begin
                    ins_d  = head_rvc ? {16'h0, head0} : {head1, head0};
                    comp_d = head_rvc;
                    val_d  = 1'b1;
                    pc_d   = hpc_q;
                    hpc_d  = hpc_q + (head_rvc ? ADDR_W'(2) : ADDR_W'(4));
                end else begin
                    ins_d  = INS_BUBBLE;
                    comp_d = 1'b0;
                    val_d  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            fa_q   <= {RESET_ADDR[ADDR_W-1:2], 2'b00};
            hpc_q  <= RESET_ADDR;
            drop_q <= RESET_ADDR[1];
            ins_q  <= INS_BUBBLE;
            comp_q <= 1'b0;
            val_q  <= 1'b0;
            pc_q   <= RESET_ADDR;
        end else begin
            fa_q   <= fa_d;
            hpc_q  <= hpc_d;
            drop_q <= drop_d;
            ins_q  <= ins_d;
            comp_q <= comp_d;
            val_q  <= val_d;
            pc_q   <= pc_d;
        end
    end

    assign fetch_addr      = fa_q;
    assign ins             = ins_q;
    assign comp_sig        = comp_q;
    assign ins_valid       = val_q;
    assign IF_ID_pres_addr = pc_q;

endmodule

// File: tb/tb_fetch_aligner.sv
// Testbench for fetch_aligner: directed per-cycle vector table plus a streaming run.
// Ports: none.
module tb_fetch_aligner;

    logic        clk = 1'b0;
    logic        Rst;
    logic [31:0] fetch_addr;
    logic        fw_valid;
    logic        fw_ready;
    logic [31:0] fw_data;
    logic        stall;
    logic        freeze;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic [31:0] ins;
    logic        comp_sig;
    logic [31:0] IF_ID_pres_addr;
    logic        ins_valid;

    int checks = 0;
    int errors = 0;

    fetch_aligner #(.ADDR_W(32), .HW_DEPTH(4), .RESET_ADDR(32'h0)) dut (
        .clk             (clk),
        .Rst             (Rst),
        .fetch_addr      (fetch_addr),
        .fw_valid        (fw_valid),
        .fw_ready        (fw_ready),
        .fw_data         (fw_data),
        .stall           (stall),
        .freeze          (freeze),
        .redirect        (redirect),
        .redirect_addr   (redirect_addr),
        .ins             (ins),
        .comp_sig        (comp_sig),
        .IF_ID_pres_addr (IF_ID_pres_addr),
        .ins_valid       (ins_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, fv;
        logic [31:0] fd;
        logic        st, fz, rd;
        logic [31:0] ra;
        logic        rdy;
        logic [31:0] ins;
        logic        comp, val;
        logic [31:0] pc, fa;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic rst, input logic fv, input logic [31:0] fd,
                       input logic st, input logic fz, input logic rd,
                       input logic [31:0] ra, input logic rdy,
                       input logic [31:0] i, input logic c, input logic v,
                       input logic [31:0] pc, input logic [31:0] fa);
        vec_t t;
        t.rst = rst; t.fv = fv; t.fd = fd; t.st = st; t.fz = fz; t.rd = rd;
        t.ra = ra; t.rdy = rdy; t.ins = i; t.comp = c; t.val = v;
        t.pc = pc; t.fa = fa;
        tv.push_back(t);
    endtask

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        int nvalid;
        logic [31:0] exp_pc;
        Rst = 1'b1; fw_valid = 1'b0; fw_data = '0; stall = 1'b0;
        freeze = 1'b0; redirect = 1'b0; redirect_addr = '0;

        //  rst fv data          st fz rd addr          rdy ins           c  v  pc            fa
        // reset + two 32-bit words back-to-back
        add(1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0);
        add(1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0);
        add(0, 1, 32'h00500093, 0, 0, 0, 32'h0,        1, 32'h0,        0, 0, 32'h0,        32'h4);
        add(0, 1, 32'h00A00113, 0, 0, 0, 32'h0,        1, 32'h00500093, 0, 1, 32'h0,        32'h8);
        add(0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h00A00113, 0, 1, 32'h4,        32'h8);
        add(0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0,        0, 0, 32'h4,        32'h8);
        // two RVC in one word
        add(1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0);
        add(0, 1, 32'h45054501, 0, 0, 0, 32'h0,        1, 32'h0,        0, 0, 32'h0,        32'h4);
        add(0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h00004501, 1, 1, 32'h0,        32'h4);
        add(0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h00004505, 1, 1, 32'h2,        32'h4);
        add(0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0,        0, 0, 32'h2,        32'h4);
        // straddling 32-bit, then lone upper half waits
        add(1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0);
        add(0, 1, 32'h00934501, 0, 0, 0, 32'h0,        1, 32'h0,        0, 0, 32'h0,        32'h4);
        add(0, 1, 32'h00130050, 0, 0, 0, 32'h0,        1, 32'h00004501, 1, 1, 32'h0,        32'h8);
        add(0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h00500093, 0, 1, 32'h2,        32'h8);
        add(0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0,        0, 0, 32'h2,        32'h8);
        add(0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0,        0, 0, 32'h2,        32'h8);
        add(0, 1, 32'h00000001, 0, 0, 0, 32'h0,        1, 32'h0,        0, 0, 32'h2,        32'hC);
        add(0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h00010013, 0, 1, 32'h6,        32'hC);
        // stall for 3 cycles: FIFO fills, fw_ready drops, no loss
        add(1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0);
        add(0, 1, 32'h00500093, 0, 0, 0, 32'h0,        1, 32'h0,        0, 0, 32'h0,        32'h4);
        add(0, 1, 32'h00A00113, 0, 0, 0, 32'h0,        1, 32'h00500093, 0, 1, 32'h0,        32'h8);
        add(0, 1, 32'h00000013, 1, 0, 0, 32'h0,        1, 32'h00500093, 0, 1, 32'h0,        32'hC);
        add(0, 1, 32'h00100093, 1, 0, 0, 32'h0,        0, 32'h00500093, 0, 1, 32'h0,        32'hC);
        add(0, 1, 32'h00100093, 1, 0, 0, 32'h0,        0, 32'h00500093, 0, 1, 32'h0,        32'hC);
        add(0, 1, 32'h00100093, 0, 0, 0, 32'h0,        0, 32'h00A00113, 0, 1, 32'h4,        32'hC);
        add(0, 1, 32'h00100093, 0, 0, 0, 32'h0,        1, 32'h00000013, 0, 1, 32'h8,        32'h10);
        add(0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h00100093, 0, 1, 32'hC,        32'h10);
        add(0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0,        0, 0, 32'hC,        32'h10);
        // redirect to 0x102 together with stall
        add(1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0);
        add(0, 1, 32'h00500093, 0, 0, 0, 32'h0,        1, 32'h0,        0, 0, 32'h0,        32'h4);
        add(0, 1, 32'h00A00113, 0, 0, 0, 32'h0,        1, 32'h00500093, 0, 1, 32'h0,        32'h8);
        add(0, 1, 32'h00000013, 1, 0, 1, 32'h102,      0, 32'h0,        0, 0, 32'h0,        32'h100);
        add(0, 1, 32'h45054501, 0, 0, 0, 32'h0,        1, 32'h0,        0, 0, 32'h0,        32'h104);
        add(0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h00004505, 1, 1, 32'h102,      32'h104);
        add(0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0,        0, 0, 32'h102,      32'h104);
        // freeze blocks push/pop and ignores redirect
        add(0, 1, 32'h00500093, 0, 0, 0, 32'h0,        1, 32'h0,        0, 0, 32'h102,      32'h108);
        add(0, 1, 32'h00A00113, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h102,      32'h108);
        add(0, 0, 32'h0,        0, 1, 1, 32'h200,      0, 32'h0,        0, 0, 32'h102,      32'h108);
        add(0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h00500093, 0, 1, 32'h104,      32'h108);
        add(0, 0, 32'h0,        0, 1, 0, 32'h0,        0, 32'h00500093, 0, 1, 32'h104,      32'h108);
        add(0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0,        0, 0, 32'h104,      32'h108);
        // address wrap
        add(0, 0, 32'h0,        0, 0, 1, 32'hFFFFFFFE, 0, 32'h0,        0, 0, 32'h104,      32'hFFFFFFFC);
        add(0, 1, 32'h45050000, 0, 0, 0, 32'h0,        1, 32'h0,        0, 0, 32'h104,      32'h0);
        add(0, 1, 32'h00004501, 0, 0, 0, 32'h0,        1, 32'h00004505, 1, 1, 32'hFFFFFFFE, 32'h4);
        add(0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h00004501, 1, 1, 32'h0,        32'h4);

        foreach (tv[i]) begin
            @(negedge clk);
            Rst = tv[i].rst; fw_valid = tv[i].fv; fw_data = tv[i].fd;
            stall = tv[i].st; freeze = tv[i].fz; redirect = tv[i].rd;
            redirect_addr = tv[i].ra;
            #1;
            check($sformatf("v%0d fw_ready", i), 128'(fw_ready), 128'(tv[i].rdy));
            @(posedge clk);
            #1;
            check($sformatf("v%0d ins/comp/valid/pc/fetch", i),
                  {ins, 3'b0, comp_sig, 3'b0, ins_valid, IF_ID_pres_addr, fetch_addr},
                  {tv[i].ins, 3'b0, tv[i].comp, 3'b0, tv[i].val, tv[i].pc, tv[i].fa});
        end

        // Streaming: continuous words, one 32-bit instruction per cycle in order.
        @(negedge clk);
        Rst = 1'b1; fw_valid = 1'b0; stall = 1'b0; freeze = 1'b0; redirect = 1'b0;
        @(negedge clk);
        Rst = 1'b0;
        nvalid = 0;
        exp_pc = 32'h0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            fw_valid = 1'b1;
            fw_data  = {fetch_addr[11:0], 20'h00013};
            @(posedge clk);
            #1;
            if (ins_valid) begin
                check($sformatf("stream pc%0h", exp_pc),
                      {ins, comp_sig, IF_ID_pres_addr},
                      {exp_pc[11:0], 20'h00013, 1'b0, exp_pc});
                exp_pc += 32'h4;
                nvalid++;
            end
        end
        check("stream count", 128'(nvalid), 128'(11));
        @(negedge clk);
        fw_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
